// File: rtl/arb_pkg.sv
// Shared definitions for the grant arbiter: state encoding, requester count,
// hold counter width and the round-robin search helper.
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int HCNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_t;

   // Round-robin search: first set request bit starting at ptr, ascending
   // with wrap. Scanning from the farthest offset down lets the nearest hit win.
   function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                          input logic [1:0]         ptr_v);
      logic [1:0] pick_v;
      logic [1:0] idx_v;
      pick_v = ptr_v;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx_v = ptr_v + k[1:0];
         if (req_v[idx_v]) begin
            pick_v = idx_v;
         end else begin
            pick_v = pick_v;
         end
      end
      return pick_v;
   endfunction

endpackage

// File: rtl/onehot_dec2x4.sv
// 2-to-4 one-hot decoder used to turn the registered grant index into gnt.
module onehot_dec2x4 (
   input  logic [1:0] sel,
   output logic [3:0] onehot
);

   // Decode the binary index into a single set bit.
   always_comb begin
      onehot = 4'b0000;
      case (sel)
         2'd0:    onehot = 4'b0001;
         2'd1:    onehot = 4'b0010;
         2'd2:    onehot = 4'b0100;
         2'd3:    onehot = 4'b1000;
         default: onehot = 4'b0000;
      endcase
   end

endmodule

// File: rtl/grant_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A grant ends either when the owner drops its request or after MAX_HOLD
// cycles; every grant is followed by one GAP cycle before re-arbitration.
// The expired pulse is recovered from the hold counter during GAP: the
// counter only reaches MAX_HOLD when the limit forced the release, so no
// extra flag register is needed.
module grant_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [1:0]         gnt_id,
   output logic               busy,
   output logic               expired
);

   localparam logic [HCNT_W-1:0] HOLD_LAST_C = HCNT_W'(MAX_HOLD - 1);
   localparam logic [HCNT_W-1:0] HOLD_EXP_C  = HCNT_W'(MAX_HOLD);

   arb_state_t          state_r;
   arb_state_t          state_nxt_s;
   logic [1:0]          gnt_id_r;
   logic [1:0]          gnt_id_nxt_s;
   logic [1:0]          ptr_r;
   logic [1:0]          ptr_nxt_s;
   logic [HCNT_W-1:0]   hcnt_r;
   logic [HCNT_W-1:0]   hcnt_nxt_s;
   logic [NUM_REQ-1:0]  dec_s;

   onehot_dec2x4 u_dec (
      .sel    (gnt_id_r),
      .onehot (dec_s)
   );

   // State, grant index, pointer and hold counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         gnt_id_r <= 2'b00;
         ptr_r    <= 2'b00;
         hcnt_r   <= {HCNT_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         gnt_id_r <= gnt_id_nxt_s;
         ptr_r    <= ptr_nxt_s;
         hcnt_r   <= hcnt_nxt_s;
      end
   end

   // Next-state logic: arbitration in IDLE, hold tracking in GRANT.
   always_comb begin
      state_nxt_s  = state_r;
      gnt_id_nxt_s = gnt_id_r;
      ptr_nxt_s    = ptr_r;
      hcnt_nxt_s   = hcnt_r;
      case (state_r)
         IDLE: begin
            hcnt_nxt_s = {HCNT_W{1'b0}};
            if (|req) begin
               state_nxt_s  = GRANT;
               gnt_id_nxt_s = rr_pick(req, ptr_r);
            end else begin
               state_nxt_s  = IDLE;
            end
         end
         GRANT: begin
            if (!req[gnt_id_r]) begin
               // Normal release wins even when the limit coincides.
               state_nxt_s = GAP;
               ptr_nxt_s   = gnt_id_r + 2'd1;
            end else if (hcnt_r == HOLD_LAST_C) begin
               // Forced release: counter steps to MAX_HOLD to mark expiry.
               state_nxt_s = GAP;
               ptr_nxt_s   = gnt_id_r + 2'd1;
               hcnt_nxt_s  = hcnt_r + {{(HCNT_W-1){1'b0}}, 1'b1};
            end else begin
               hcnt_nxt_s  = hcnt_r + {{(HCNT_W-1){1'b0}}, 1'b1};
            end
         end
         GAP: begin
            state_nxt_s = IDLE;
            hcnt_nxt_s  = {HCNT_W{1'b0}};
         end
         default: begin
            state_nxt_s = IDLE;
            hcnt_nxt_s  = {HCNT_W{1'b0}};
         end
      endcase
   end

   // Outputs come only from registered state, index and counter.
   always_comb begin
      gnt     = (state_r == GRANT) ? dec_s : 4'b0000;
      gnt_id  = gnt_id_r;
      busy    = (state_r != IDLE);
      expired = (state_r == GAP) && (hcnt_r == HOLD_EXP_C);
   end

endmodule

// File: tb/tb_grant_arbiter.sv
// Self-checking bench for grant_arbiter (MAX_HOLD=4): directed scenarios
// with literal expectations, then randomized requests and resets checked
// every cycle against an owner/hold-count model of the arbitration rules.
module tb_grant_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       expired;

   int total;
   int bad;

   // Model: who owns the resource (-1 = nobody), how many cycles it has owned
   // it, whether we sit in the post-grant gap, last winner, next search start.
   int m_owner = -1;
   int m_owned = 0;
   bit m_gap   = 1'b0;
   int m_last  = 0;
   int m_start = 0;
   bit m_exp   = 1'b0;

   grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .expired (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, want);
      end
   endtask

   // Reference model update on every clock edge or reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = -1; m_owned = 0; m_gap = 1'b0;
         m_last  = 0;  m_start = 0; m_exp = 1'b0;
      end else begin
         m_exp = 1'b0;
         if (m_owner >= 0) begin
            if (!req[m_owner]) begin
               m_start = (m_owner + 1) % 4; m_owner = -1; m_gap = 1'b1;
            end else if (m_owned == MAX_HOLD) begin
               m_start = (m_owner + 1) % 4; m_owner = -1; m_gap = 1'b1;
               m_exp = 1'b1;
            end else begin
               m_owned++;
            end
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else if (req != 4'b0000) begin
            for (int k = 3; k >= 0; k--) begin
               if (req[(m_start + k) % 4]) m_owner = (m_start + k) % 4;
            end
            m_last  = m_owner;
            m_owned = 1;
         end
      end
   end

   // Compare DUT outputs with the model every cycle, away from the edge.
   always @(negedge clk) begin
      logic [3:0] want_gnt;
      want_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check("m_gnt", gnt, want_gnt);
      check("m_gnt_id", {2'b00, gnt_id}, 4'(m_last));
      check("m_busy", {3'b000, busy}, {3'b000, (m_owner >= 0) || m_gap});
      check("m_expired", {3'b000, expired}, {3'b000, m_exp});
   end

   task automatic cyc(input logic [3:0] r);
      req = r;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] r;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req   = 4'b0000;
      repeat (2) @(negedge clk);
      #1;
      check("rst_gnt", gnt, 4'b0000);
      check("rst_id", {2'b00, gnt_id}, 4'b0000);
      check("rst_busy", {3'b000, busy}, 4'b0000);
      rst = 1'b0;

      // Single requester and release through GAP to IDLE.
      cyc(4'b0100);
      check("single_gnt", gnt, 4'b0100);
      check("single_id", {2'b00, gnt_id}, 4'b0010);
      cyc(4'b0000);
      check("gap_gnt", gnt, 4'b0000);
      check("gap_busy", {3'b000, busy}, 4'b0001);
      check("gap_exp", {3'b000, expired}, 4'b0000);
      cyc(4'b0000);
      check("idle_busy", {3'b000, busy}, 4'b0000);
      check("idle_id_hold", {2'b00, gnt_id}, 4'b0010);

      // Pointer wrap after requester 3.
      cyc(4'b1000);
      check("wrap_g3", gnt, 4'b1000);
      cyc(4'b0000); cyc(4'b0000);
      cyc(4'b1001);
      check("wrap_gnt", gnt, 4'b0001);
      check("wrap_id", {2'b00, gnt_id}, 4'b0000);
      cyc(4'b0000); cyc(4'b0000);

      // Fairness with all requesting, starting from a fresh pointer.
      rst = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < MAX_HOLD; c++) begin
            cyc(4'b1111);
            check("fair_gnt", gnt, 4'b0001 << (g % 4));
         end
         cyc(4'b1111);
         check("fair_exp", {3'b000, expired}, 4'b0001);
         check("fair_gap", gnt, 4'b0000);
         cyc(4'b1111);
         check("fair_idle", {3'b000, busy}, 4'b0000);
      end

      // Release coinciding with the hold limit: no expiry pulse.
      for (int c = 0; c < MAX_HOLD; c++) begin
         cyc(4'b0010);
         check("coinc_gnt", gnt, 4'b0010);
      end
      cyc(4'b0000);
      check("coinc_exp", {3'b000, expired}, 4'b0000);
      check("coinc_busy", {3'b000, busy}, 4'b0001);
      cyc(4'b0000);

      // Other requesters toggling do not disturb the owner.
      cyc(4'b0010);
      check("nonown_gnt0", gnt, 4'b0010);
      cyc(4'b1110); check("nonown_gnt1", gnt, 4'b0010);
      cyc(4'b0011); check("nonown_gnt2", gnt, 4'b0010);
      cyc(4'b1110); check("nonown_gnt3", gnt, 4'b0010);
      cyc(4'b0011);
      check("nonown_exp", {3'b000, expired}, 4'b0001);
      check("nonown_drop", gnt, 4'b0000);
      cyc(4'b0000);

      // Asynchronous reset during a grant.
      cyc(4'b0100);
      check("mid_gnt", gnt, 4'b0100);
      rst = 1'b1;
      #1;
      check("async_gnt", gnt, 4'b0000);
      check("async_id", {2'b00, gnt_id}, 4'b0000);
      check("async_busy", {3'b000, busy}, 4'b0000);
      check("async_exp", {3'b000, expired}, 4'b0000);
      @(negedge clk);
      #1;
      rst = 1'b0;
      cyc(4'b1111);
      check("post_rst_gnt", gnt, 4'b0001);
      check("post_rst_id", {2'b00, gnt_id}, 4'b0000);

      // Randomized traffic with occasional resets.
      r = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            #1;
            rst = 1'b0;
         end else begin
            case ($urandom_range(0, 3))
               0:       r = 4'($urandom_range(0, 15));
               1:       r = r ^ (4'b0001 << $urandom_range(0, 3));
               default: r = r;
            endcase
            cyc(r);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/grant_arbiter.md
GRANT_ARBITER -- requirements
Module: grant_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive cycles one grant is held; legal range 2..255.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 Port req, input, 4 bits, SHALL carry one request per requester; requester k is bit k.
REQ-005 Port gnt, output, 4 bits, SHALL be the one-hot grant to the requester owning the shared resource.
REQ-006 Port gnt_id, output, 2 bits, SHALL be the binary index of the current or most recent grant.
REQ-007 Port busy, output, 1 bit, SHALL be high whenever the state is not IDLE.
REQ-008 Port expired, output, 1 bit, SHALL pulse high for one cycle when a grant is forcibly ended by the MAX_HOLD limit.

Function
REQ-009 States: IDLE, GRANT, GAP; the state register, gnt_id, round-robin pointer ptr (2 bits) and hold counter hcnt (8 bits) SHALL be the only storage.
REQ-010 IDLE with req=0000 SHALL remain in IDLE, gnt=0000.
REQ-011 IDLE with any req bit set SHALL, at the next edge, load gnt_id with the first set bit searching ptr, ptr+1, ... ascending with wrap 3->0; it SHALL enter GRANT with hcnt=0.
REQ-012 Grant latency SHALL be exactly one cycle: req sampled in IDLE on edge N gives gnt valid after edge N.
REQ-013 In GRANT, gnt SHALL equal the one-hot decode of gnt_id; exactly one bit is set.
REQ-014 In GRANT, gnt SHALL be 0000 in IDLE and GAP; it SHALL never have more than one bit set.
REQ-015 In GRANT, hcnt SHALL increment by one per cycle and SHALL not wrap.
REQ-016 GRANT with req[gnt_id]=0 SHALL go to GAP at the next edge (normal release, expired stays 0).
REQ-017 GRANT with req[gnt_id]=1 and hcnt=MAX_HOLD-1 SHALL go to GAP at the next edge with expired=1 for that one following cycle.
REQ-018 If release and the MAX_HOLD limit coincide in the same cycle, the event SHALL be treated as a normal release, with no expired pulse.
REQ-019 On the edge entering GAP, ptr SHALL be loaded with gnt_id+1 modulo 4.
REQ-020 GAP SHALL last exactly one cycle with gnt=0000, then go to IDLE; requests arriving in GAP are held off until IDLE.
REQ-021 Changes on req bits other than the granted bit SHALL not affect GRANT.
REQ-022 gnt_id SHALL hold its value through GAP and IDLE until the next arbitration.

Reset
REQ-023 rst=1 SHALL immediately, regardless of clock, force state=IDLE, gnt=0000, gnt_id=00, ptr=00, hcnt=0, busy=0, expired=0.
REQ-024 Reset asserted mid-GRANT SHALL drop gnt asynchronously with no GAP cycle; after release, first arbitration SHALL start from ptr=00.

Structure
REQ-025 A shared package arb_pkg SHALL hold the state encoding (IDLE=2'b00, GRANT=2'b01, GAP=2'b10), NUM_REQ=4 and the hcnt width constant.
REQ-026 The one-hot decode of gnt_id SHALL be the sub-module onehot_dec2x4 (2-bit in, 4-bit one-hot out), instantiated once.
REQ-027 The outputs gnt, busy and expired SHALL be driven directly from registers or from the decode of registered gnt_id, gated by state, with no combinational path from req.

Verification
REQ-028 Reset: rst=1 during active grant gnt=0100 -> gnt=0000, gnt_id=00, busy=0, expired=0 before the next clk edge.
REQ-029 Single requester: req=0100 in IDLE -> next edge gnt=0100, gnt_id=10; req->0000 -> next edge gnt=0000 (GAP), following edge IDLE, busy=0.
REQ-030 Fairness: MAX_HOLD=4, req=1111 held -> gnt sequence 0001,0010,0100,1000,0001, each 4 cycles, each followed by expired=1 and one 0000 gap cycle.
REQ-031 Pointer wrap: after grant to requester 3 ends, req=1001 -> gnt=0001, gnt_id=00.
REQ-032 Coincident events: MAX_HOLD=4, granted req dropped in the cycle hcnt=3 -> GAP entered, expired stays 0.
REQ-033 Non-owner activity: gnt=0010 while req toggles between 0011 and 1110 -> gnt stays 0010 until req[1]=0 or expiry.
